// File: rtl/dsa_modmul_pkg.sv
// dsa_modmul shared definitions.
// Widths, state encodings and count sizing for the modular multiplier.
package dsa_modmul_pkg;

    localparam int SIZE_DEF = 256;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int CNT_W_DEF = cnt_w(SIZE_DEF);

endpackage

// File: rtl/dsa_modmul_step.sv
// dsa_modmul single iteration.
// acc_next = (2*acc + (abit ? b : 0)) reduced by up to two subtractions of p.
import dsa_modmul_pkg::*;

module dsa_modmul_step #(
    parameter int SIZE = SIZE_DEF
) (
    input  logic [SIZE-1:0] acc,
    input  logic [SIZE-1:0] b,
    input  logic [SIZE-1:0] p,
    input  logic            abit,
    output logic [SIZE-1:0] acc_next
);

    logic [SIZE+1:0] pw;
    logic [SIZE+1:0] t;
    logic [SIZE+1:0] t1;

    // Double-and-add at SIZE+2 bits, then reduce below p.
    always_comb begin
        pw = {2'b00, p};
        t  = {1'b0, acc, 1'b0} + (abit ? {2'b00, b} : '0);
        t1 = (t >= pw) ? t - pw : t;
        if (t1 >= pw) begin
            acc_next = SIZE'(t1 - pw);
        end else begin
            acc_next = SIZE'(t1);
        end
    end

endmodule

// File: rtl/dsa_modmul.sv
// dsa_modmul: bit-serial MSB-first modular multiplier, c = a*b mod p.
// en low loads operands; en high runs SIZE iterations then holds result.
import dsa_modmul_pkg::*;

module dsa_modmul #(
    parameter int SIZE = SIZE_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic [SIZE-1:0] p,
    output logic            rdy,
    output logic [SIZE-1:0] c
);

    localparam int CW = cnt_w(SIZE);
    localparam logic [CW-1:0] CNT_TOP = CW'(SIZE - 1);

    state_t          state_q, state_d;
    logic [SIZE-1:0] a_q, a_d;
    logic [SIZE-1:0] b_q, b_d;
    logic [SIZE-1:0] p_q, p_d;
    logic [SIZE-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] c_d;
    logic            rdy_d;
    logic [SIZE-1:0] acc_step;

    dsa_modmul_step #(
        .SIZE(SIZE)
    ) u_step (
        .acc     (acc_q),
        .b       (b_q),
        .p       (p_q),
        .abit    (a_q[cnt_q]),
        .acc_next(acc_step)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= CNT_TOP;
            c       <= '0;
            rdy     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            c       <= c_d;
            rdy     <= rdy_d;
        end
    end

    // Next-state: en low always reloads; otherwise iterate until bit 0.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        c_d     = c;
        rdy_d   = rdy;
        if (!en) begin
            a_d     = a;
            b_d     = b;
            p_d     = p;
            acc_d   = '0;
            cnt_d   = CNT_TOP;
            c_d     = '0;
            rdy_d   = 1'b0;
            state_d = RUN;
        end else begin
            case (state_q)
                LOAD: begin
                    state_d = LOAD;
                end
                RUN: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        c_d     = acc_step;
                        rdy_d   = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = LOAD;
                    acc_d   = '0;
                    cnt_d   = CNT_TOP;
                    c_d     = '0;
                    rdy_d   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsa_modmul.sv
// Self-checking bench for dsa_modmul at SIZE=8 and SIZE=256.
// Scoreboard queues per instance; monitors compare on rdy rise.
module tb_dsa_modmul;

    typedef logic [255:0] u256;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       chain;
    logic       en8_d;
    logic [7:0] a8_d, b8, p8;
    logic       en8;
    logic [7:0] a8;
    logic       rdy8;
    logic [7:0] c8;

    logic       inv_en, inv_rdy;
    logic [7:0] inv_c, inv_k;
    int         inv_cnt;

    logic en2;
    u256  a2, b2, p2;
    logic rdy2;
    u256  c2;

    assign en8 = chain ? inv_rdy : en8_d;
    assign a8  = chain ? inv_c : a8_d;

    dsa_modmul #(.SIZE(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8),
        .a(a8), .b(b8), .p(p8), .rdy(rdy8), .c(c8)
    );

    dsa_modmul #(.SIZE(256)) dut256 (
        .clk(clk), .rst_n(rst_n), .en(en2),
        .a(a2), .b(b2), .p(p2), .rdy(rdy2), .c(c2)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] q8[$];
    u256        q2[$];
    int         hi8, hi2;
    logic       prev8 = 1'b0, prev2 = 1'b0;
    logic [7:0] held8;
    u256        held2;

    task automatic check(input string name, input u256 act, input u256 exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [7:0] ref8(input logic [7:0] x, y, m);
        return 8'((int'(x) * int'(y)) % int'(m));
    endfunction

    function automatic u256 ref256(input u256 x, y, m);
        logic [511:0] pr;
        pr = {256'b0, x} * {256'b0, y};
        return u256'(pr % {256'b0, m});
    endfunction

    function automatic logic [7:0] inv_of(input logic [7:0] k, q);
        for (int x = 1; x < int'(q); x++)
            if ((int'(k) * x) % int'(q) == 1) return 8'(x);
        return 8'd0;
    endfunction

    function automatic u256 rnd256();
        u256 r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
        return r;
    endfunction

    // Behavioural upstream inverse stage: value at edge 4, rdy at edge 5.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_rdy <= 1'b0;
            inv_cnt <= 0;
            inv_c   <= 8'd0;
        end else if (!inv_en) begin
            inv_rdy <= 1'b0;
            inv_cnt <= 0;
        end else begin
            inv_cnt <= inv_cnt + 1;
            if (inv_cnt == 3) inv_c <= inv_of(inv_k, 8'h0B);
            if (inv_cnt == 4) inv_rdy <= 1'b1;
        end
    end

    // Count consecutive edges with en sampled high.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi8 <= 0;
            hi2 <= 0;
        end else begin
            hi8 <= en8 ? hi8 + 1 : 0;
            hi2 <= en2 ? hi2 + 1 : 0;
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev8 = 1'b0;
        end else begin
            if (rdy8 && !prev8) begin
                if (q8.size() == 0) begin
                    flag("rdy8 rose with nothing expected");
                end else begin
                    check("c8", u256'(c8), u256'(q8.pop_front()));
                    check("lat8", u256'(hi8), u256'(8));
                end
                held8 = c8;
            end else if (prev8 && hi8 > 0) begin
                check("rdy8 hold", u256'(rdy8), u256'(1));
                check("c8 hold", u256'(c8), u256'(held8));
            end else if (!rdy8) begin
                check("c8 idle zero", u256'(c8), u256'(0));
            end
            prev8 = rdy8;
        end
    end

    // Monitor for the 256-bit instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev2 = 1'b0;
        end else begin
            if (rdy2 && !prev2) begin
                if (q2.size() == 0) begin
                    flag("rdy2 rose with nothing expected");
                end else begin
                    check("c256", c2, q2.pop_front());
                    check("lat256", u256'(hi2), u256'(256));
                end
                held2 = c2;
            end else if (prev2 && hi2 > 0) begin
                check("rdy256 hold", u256'(rdy2), u256'(1));
                check("c256 hold", c2, held2);
            end
            prev2 = rdy2;
        end
    end

    task automatic wait_rdy8(input int maxc);
        int n = 0;
        while (!rdy8 && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rdy8) begin
            flag("timeout waiting rdy8");
            q8.delete();
        end
    endtask

    task automatic wait_rdy2(input int maxc);
        int n = 0;
        while (!rdy2 && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rdy2) begin
            flag("timeout waiting rdy256");
            q2.delete();
        end
    endtask

    task automatic run8(input logic [7:0] x, y, m, e, input int hold);
        @(posedge clk); #1;
        en8_d = 1'b0;
        a8_d  = x;
        b8    = y;
        p8    = m;
        @(posedge clk); #1;
        q8.push_back(e);
        en8_d = 1'b1;
        wait_rdy8(20);
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic run2(input u256 x, y, m, e);
        @(posedge clk); #1;
        en2 = 1'b0;
        a2  = x;
        b2  = y;
        p2  = m;
        @(posedge clk); #1;
        q2.push_back(e);
        en2 = 1'b1;
        wait_rdy2(300);
        @(posedge clk); #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        u256 P;
        logic [7:0] rm, ra, rb;
        u256 xa, xb;
        rst_n  = 1'b0;
        chain  = 1'b0;
        inv_en = 1'b0;
        inv_k  = 8'd0;
        en8_d  = 1'b0;
        a8_d   = 8'd0;
        b8     = 8'd0;
        p8     = 8'd0;
        en2    = 1'b0;
        a2     = '0;
        b2     = '0;
        p2     = '0;
        #12;
        check("reset c8", u256'(c8), u256'(0));
        check("reset rdy8", u256'(rdy8), u256'(0));
        check("reset c256", c2, u256'(0));
        check("reset rdy256", u256'(rdy2), u256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        run8(8'h05, 8'h07, 8'h0B, 8'h02, 20);
        run8(8'h0A, 8'h0A, 8'h0B, 8'h01, 0);
        run8(8'h00, 8'h09, 8'h0B, 8'h00, 0);
        run8(8'h01, 8'h01, 8'h02, 8'h01, 0);

        for (int i = 0; i < 30; i++) begin
            rm = 8'($urandom_range(2, 255));
            ra = 8'($urandom_range(0, int'(rm) - 1));
            rb = 8'($urandom_range(0, int'(rm) - 1));
            run8(ra, rb, rm, ref8(ra, rb, rm), 0);
        end

        @(posedge clk); #1;
        en8_d = 1'b0;
        a8_d  = 8'h05;
        b8    = 8'h07;
        p8    = 8'h0B;
        @(posedge clk); #1;
        en8_d = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        en8_d = 1'b0;
        @(posedge clk); #1;
        check("abort rdy8", u256'(rdy8), u256'(0));
        check("abort c8", u256'(c8), u256'(0));
        a8_d = 8'h03;
        b8   = 8'h04;
        @(posedge clk); #1;
        q8.push_back(8'h01);
        en8_d = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        a8_d = 8'hFF;
        b8   = 8'h0A;
        wait_rdy8(20);
        @(posedge clk); #1;

        run8(8'h05, 8'h07, 8'h0B, 8'h02, 2);
        #3;
        rst_n = 1'b0;
        #1;
        check("async rst c8", u256'(c8), u256'(0));
        check("async rst rdy8", u256'(rdy8), u256'(0));
        en8_d = 1'b0;
        #2;
        rst_n = 1'b1;
        run8(8'h05, 8'h07, 8'h0B, 8'h02, 0);

        @(posedge clk); #1;
        en8_d = 1'b0;
        a8_d  = 8'h01;
        b8    = 8'h02;
        p8    = 8'h0B;
        @(posedge clk); #1;
        en8_d = 1'b1;
        repeat (3) @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        check("midrun rst rdy8", u256'(rdy8), u256'(0));
        check("midrun rst c8", u256'(c8), u256'(0));
        en8_d = 1'b0;
        #2;
        rst_n = 1'b1;

        @(posedge clk); #1;
        chain  = 1'b1;
        b8     = 8'h05;
        p8     = 8'h0B;
        inv_k  = 8'h03;
        q8.push_back(8'h09);
        inv_en = 1'b1;
        wait_rdy8(30);
        @(posedge clk); #1;
        inv_en = 1'b0;
        @(posedge clk); #1;
        chain  = 1'b0;
        en8_d  = 1'b0;

        P = (u256'(1) << 255) - u256'(19);
        run2(P - 1, P - 1, P, u256'(1));
        run2(u256'(2), (P + 1) >> 1, P, u256'(1));
        run2(u256'(0), P - 5, P, u256'(0));
        for (int i = 0; i < 240; i++) begin
            xa = rnd256() % P;
            xb = rnd256() % P;
            run2(xa, xb, P, ref256(xa, xb, P));
        end
        en2 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("q8 drained", u256'(q8.size()), u256'(0));
        check("q256 drained", u256'(q2.size()), u256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
